// File: rtl/reg_encoder.sv
// Register-request encoder: captures an 8-bit request vector and serves one register code per
// handshake. Define REG_ENCODER_ROUND_ROBIN_EN for round-robin arbitration (default: fixed priority, r7 first).
module reg_encoder (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       req_valid,
    output logic       req_ready,
    output logic [2:0] register,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] pending_count
);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] pending;
    logic [7:0] pending_left;
    logic [2:0] sel;
    logic       capture;
    logic       xfer;

`ifdef REG_ENCODER_ROUND_ROBIN_EN
    logic [2:0] ptr;
    logic [2:0] idx;
    logic       found;

    // Walk downward from the pointer, wrapping 0 -> 7; first set bit wins.
    always_comb begin
        sel   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr - 3'(k);
            if (!found && pending[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            ptr <= 3'd7;
        else if (xfer)
            ptr <= sel - 3'd1;
    end
`else
    // Ascending scan so the highest set index overrides lower ones.
    always_comb begin
        sel = 3'd0;
        for (int k = 0; k < 8; k++)
            if (pending[k])
                sel = 3'(k);
    end
`endif

    assign capture      = (state == IDLE) && req_valid && (req != 8'd0);
    assign xfer         = (state == SERVE) && out_ready;
    assign pending_left = pending & ~(8'd1 << sel);

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            pending <= 8'd0;
        end else begin
            state <= state_nxt;
            if (capture)
                pending <= req;
            else if (xfer)
                pending <= pending_left;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (capture) state_nxt = SERVE;
            SERVE:   if (xfer && (pending_left == 8'd0)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready     = 1'b0;
        out_valid     = 1'b0;
        register      = 3'd0;
        pending_count = 4'd0;
        if (state == SERVE) begin
            out_valid = 1'b1;
            register  = 3'd7 - sel;
            for (int k = 0; k < 8; k++)
                pending_count = pending_count + 4'(pending[k]);
        end else begin
            req_ready = 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_encoder.sv
// Randomized and directed check of reg_encoder against a set-of-pending-bits model.
module tb_reg_encoder;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] req = 8'd0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [2:0] register;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] pending_count;

    int errors = 0;
    int checks = 0;

    // Model: busy flag, set of pending register indices, round-robin pointer.
    bit  m_busy = 1'b0;
    bit  m_pend [8];
    int  m_ptr = 7;

    reg_encoder dut (
        .clock         (clock),
        .reset         (reset),
        .req           (req),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .register      (register),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .pending_count (pending_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    function automatic int m_sel();
        for (int k = 0; k < 8; k++) begin
`ifdef REG_ENCODER_ROUND_ROBIN_EN
            int i = ((m_ptr - k) % 8 + 8) % 8;
`else
            int i = 7 - k;
`endif
            if (m_pend[i]) return i;
        end
        return 0;
    endfunction

    // Drive one cycle's inputs (called at a falling edge), advance the model
    // by that rising edge, then compare DUT against the model at the next falling edge.
    task automatic cyc(input bit rv, input logic [7:0] r, input bit ord, input bit rst);
        int s;
        reset     = rst;
        req_valid = rv;
        req       = r;
        out_ready = ord;
        if (rst) begin
            m_busy = 0;
            m_ptr  = 7;
            for (int i = 0; i < 8; i++) m_pend[i] = 0;
        end else if (!m_busy) begin
            if (rv && r != 8'd0) begin
                for (int i = 0; i < 8; i++) m_pend[i] = r[i];
                m_busy = 1;
            end
        end else if (ord) begin
            s = m_sel();
            m_pend[s] = 0;
            m_ptr = (s + 7) % 8;
            if (m_count() == 0) m_busy = 0;
        end
        @(negedge clock);
        check("model_req_ready", int'(req_ready), int'(!m_busy));
        check("model_out_valid", int'(out_valid), int'(m_busy));
        check("model_register", int'(register), m_busy ? 7 - m_sel() : 0);
        check("model_pending_count", int'(pending_count), m_busy ? m_count() : 0);
    endtask

    initial begin
        logic [7:0] r;
        @(negedge clock);
        cyc(0, 8'h00, 0, 1);
        check("reset_req_ready", int'(req_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_register", int'(register), 0);
        check("reset_count", int'(pending_count), 0);

`ifndef REG_ENCODER_ROUND_ROBIN_EN
        cyc(1, 8'h80, 0, 0);
        check("b7_valid", int'(out_valid), 1);
        check("b7_code", int'(register), 0);
        check("b7_count", int'(pending_count), 1);
        cyc(0, 8'h00, 1, 0);
        check("b7_back_idle", int'(req_ready), 1);
        cyc(1, 8'h01, 0, 0);
        check("b0_code", int'(register), 7);
        cyc(0, 8'h00, 1, 0);
        cyc(1, 8'h24, 1, 0);
        check("h24_first", int'(register), 2);
        cyc(0, 8'h00, 1, 0);
        check("h24_second", int'(register), 5);
        cyc(0, 8'h00, 1, 0);
        check("h24_done", int'(out_valid), 0);

        cyc(1, 8'hFF, 0, 0);
        check("ff_first", int'(register), 0);
        for (int i = 0; i < 8; i++) begin
            cyc(0, 8'h00, 0, 0);
            check("ff_hold_code", int'(register), i);
            check("ff_hold_count", int'(pending_count), 8 - i);
            cyc(0, 8'h00, 1, 0);
            if (i < 7) check("ff_next_code", int'(register), i + 1);
            else       check("ff_done", int'(out_valid), 0);
        end

        cyc(1, 8'h00, 0, 0);
        check("zero_no_out", int'(out_valid), 0);
        check("zero_ready", int'(req_ready), 1);

        cyc(1, 8'h81, 0, 0);
        cyc(1, 8'h7E, 1, 0);
        check("ignore_code", int'(register), 7);
        check("ignore_count", int'(pending_count), 1);
        cyc(0, 8'h00, 1, 0);
        check("ignore_done", int'(out_valid), 0);

        cyc(1, 8'hF0, 0, 0);
        cyc(0, 8'h00, 1, 0);
        check("f0_second", int'(register), 1);
        check("f0_count", int'(pending_count), 3);
        cyc(1, 8'h0F, 1, 1);
        check("rst_mid_valid", int'(out_valid), 0);
        check("rst_mid_count", int'(pending_count), 0);
        cyc(0, 8'h00, 1, 0);
        check("rst_mid_quiet", int'(out_valid), 0);
`else
        cyc(1, 8'h81, 1, 0);
        check("rr_81_first", int'(register), 0);
        cyc(0, 8'h00, 1, 0);
        check("rr_81_second", int'(register), 7);
        cyc(0, 8'h00, 1, 0);
        cyc(1, 8'h41, 1, 0);
        check("rr_41_first", int'(register), 1);
        cyc(0, 8'h00, 1, 0);
        check("rr_41_second", int'(register), 7);
        cyc(0, 8'h00, 1, 0);
        cyc(1, 8'h82, 1, 0);
        check("rr_82_first", int'(register), 0);
        cyc(0, 8'h00, 1, 0);
        check("rr_82_second", int'(register), 6);
        cyc(0, 8'h00, 1, 0);
        cyc(1, 8'h81, 1, 0);
        check("rr_wrap_first", int'(register), 7);
        cyc(0, 8'h00, 1, 0);
        check("rr_wrap_second", int'(register), 0);
        cyc(0, 8'h00, 1, 0);
`endif

        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 5))
                0:       r = 8'd0;
                1:       r = 8'd1 << $urandom_range(0, 7);
                2:       r = 8'hFF;
                default: r = 8'($urandom);
            endcase
            cyc(1'($urandom_range(0, 1)), r, ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 49) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
